// File: rtl/lza_cc_encoder.sv
// rtl/lza_cc_encoder.sv - LZA concurrent-correction leading-digit encoder, 2-stage valid/ready pipeline
module lza_cc_encoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sel_neg,
    input  logic [DATA_WIDTH-1:0]  string_n_pos,
    input  logic [DATA_WIDTH-1:0]  string_z_pos,
    input  logic [DATA_WIDTH-1:0]  string_p_pos,
    input  logic [DATA_WIDTH-1:0]  string_n_neg,
    input  logic [DATA_WIDTH-1:0]  string_z_neg,
    input  logic [DATA_WIDTH-1:0]  string_p_neg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SHIFT_WIDTH-1:0] shift_amt,
    output logic [SHIFT_WIDTH-1:0] lead_pos,
    output logic                   corr,
    output logic                   zero,
    output logic                   invalid
);

    localparam logic [SHIFT_WIDTH-1:0] W_VAL = SHIFT_WIDTH'(DATA_WIDTH);
    localparam logic [SHIFT_WIDTH-1:0] MAX_K = SHIFT_WIDTH'(DATA_WIDTH - 1);

    // z digits are implied by absence of p and n, so the z strings carry no information.
    logic unused_z;
    assign unused_z = ^{string_z_pos, string_z_neg};

    // Pipeline control
    logic s1_valid, s2_valid;
    logic s1_ready, s2_ready;

    assign s2_ready  = ~s2_valid | out_ready;
    assign s1_ready  = ~s1_valid | s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s2_valid;

    // Stage 1 combinational: select, decode (p wins over n), find leading mask
    logic [DATA_WIDTH-1:0] sel_p, sel_n;
    logic [DATA_WIDTH-1:0] dec_p, dec_n, dec_nz;
    logic [DATA_WIDTH-1:0] lead_mask;
    logic                  dec_zero;

    assign sel_p    = sel_neg ? string_p_neg : string_p_pos;
    assign sel_n    = sel_neg ? string_n_neg : string_n_pos;
    assign dec_p    = sel_p;
    assign dec_n    = sel_n & ~sel_p;
    assign dec_nz   = dec_p | dec_n;
    assign dec_zero = ~|dec_nz;

    always_comb begin
        lead_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (dec_nz[i]) begin
                lead_mask    = '0;
                lead_mask[i] = 1'b1;
            end
        end
    end

    // Stage 1 registers
    logic [DATA_WIDTH-1:0] s1_p, s1_n, s1_mask;
    logic                  s1_zero, s1_sel_neg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_p       <= '0;
            s1_n       <= '0;
            s1_mask    <= '0;
            s1_zero    <= 1'b0;
            s1_sel_neg <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p       <= dec_p;
                s1_n       <= dec_n;
                s1_mask    <= lead_mask;
                s1_zero    <= dec_zero;
                s1_sel_neg <= sel_neg;
            end
        end
    end

    // Stage 2 combinational: encode k, evaluate correction and sign check
    logic [DATA_WIDTH-1:0]  exp_str, cnt_str, below_mask;
    logic [SHIFT_WIDTH-1:0] enc_k, c_shift;
    logic                   below_found, below_cnt;
    logic                   exp_at_k, cnt_at_k, c_corr, c_invalid;

    assign exp_str    = s1_sel_neg ? s1_n : s1_p;
    assign cnt_str    = s1_sel_neg ? s1_p : s1_n;
    // One-hot minus one sets exactly the positions strictly below k.
    assign below_mask = s1_mask - DATA_WIDTH'(1);

    always_comb begin
        enc_k       = '0;
        below_found = 1'b0;
        below_cnt   = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (s1_mask[i]) begin
                enc_k = enc_k | SHIFT_WIDTH'(i);
            end
            // Ascending scan: the last hit is the first non-z digit below k.
            if (below_mask[i] && (s1_p[i] || s1_n[i])) begin
                below_found = 1'b1;
                below_cnt   = cnt_str[i];
            end
        end
    end

    assign exp_at_k  = |(s1_mask & exp_str);
    assign cnt_at_k  = |(s1_mask & cnt_str);
    assign c_corr    = exp_at_k & below_found & below_cnt;
    assign c_invalid = cnt_at_k;
    assign c_shift   = s1_zero ? W_VAL
                               : (MAX_K - enc_k + {{(SHIFT_WIDTH-1){1'b0}}, c_corr});

    // Stage 2 registers drive the outputs directly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            shift_amt <= '0;
            lead_pos  <= '0;
            corr      <= 1'b0;
            zero      <= 1'b0;
            invalid   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                shift_amt <= c_shift;
                lead_pos  <= enc_k;
                corr      <= c_corr;
                zero      <= s1_zero;
                invalid   <= c_invalid;
            end
        end
    end

endmodule

// File: tb/tb_lza_cc_encoder.sv
// tb/tb_lza_cc_encoder.sv - directed self-checking bench for lza_cc_encoder
module tb_lza_cc_encoder;

    localparam int W  = 8;
    localparam int SW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          sel_neg;
    logic [W-1:0]  string_n_pos, string_z_pos, string_p_pos;
    logic [W-1:0]  string_n_neg, string_z_neg, string_p_neg;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] shift_amt;
    logic [SW-1:0] lead_pos;
    logic          corr;
    logic          zero;
    logic          invalid;

    int checks   = 0;
    int failures = 0;

    lza_cc_encoder #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sel_neg      (sel_neg),
        .string_n_pos (string_n_pos),
        .string_z_pos (string_z_pos),
        .string_p_pos (string_p_pos),
        .string_n_neg (string_n_neg),
        .string_z_neg (string_z_neg),
        .string_p_neg (string_p_neg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .shift_amt    (shift_amt),
        .lead_pos     (lead_pos),
        .corr         (corr),
        .zero         (zero),
        .invalid      (invalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives the selected set; the unselected set gets conflicting junk.
    task automatic drive(input logic sn, input logic [W-1:0] p, input logic [W-1:0] n);
        sel_neg = sn;
        if (sn) begin
            string_p_neg = p;  string_n_neg = n;  string_z_neg = ~(p | n);
            string_p_pos = ~p; string_n_pos = p;  string_z_pos = n;
        end else begin
            string_p_pos = p;  string_n_pos = n;  string_z_pos = ~(p | n);
            string_p_neg = ~p; string_n_neg = p;  string_z_neg = n;
        end
    endtask

    task automatic run_one(input string tag, input logic sn, input logic [W-1:0] p,
                           input logic [W-1:0] n, input int k, input int c,
                           input int sh, input int z, input int inv);
        drive(sn, p, n);
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_out_valid_t1"}, int'(out_valid), 0);
        tick();
        chk({tag, "_out_valid_t2"}, int'(out_valid), 1);
        chk({tag, "_lead_pos"}, int'(lead_pos), k);
        chk({tag, "_corr"}, int'(corr), c);
        chk({tag, "_shift_amt"}, int'(shift_amt), sh);
        chk({tag, "_zero"}, int'(zero), z);
        chk({tag, "_invalid"}, int'(invalid), inv);
        tick();
        chk({tag, "_drained"}, int'(out_valid), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(1'b0, 8'b1000_0000, 8'b0000_0000);
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_shift_amt", int'(shift_amt), 0);
        chk("rst_lead_pos", int'(lead_pos), 0);
        chk("rst_flags", int'({corr, zero, invalid}), 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        tick();
        chk("rst_no_capture", int'(out_valid), 0);

        // z z p z z n z z
        run_one("t1_corr", 1'b0, 8'b0010_0000, 8'b0000_0100, 5, 1, 3, 0, 0);
        // z p z z z z z p
        run_one("t2_nocorr", 1'b0, 8'b0100_0001, 8'b0000_0000, 6, 0, 1, 0, 0);
        // sel_neg: n z z z p z z z
        run_one("t3_neg_corr", 1'b1, 8'b0000_1000, 8'b1000_0000, 7, 1, 1, 0, 0);
        run_one("t3_allz", 1'b1, 8'b0000_0000, 8'b0000_0000, 0, 0, 8, 1, 0);
        // z z z n z z z z
        run_one("t4_invalid", 1'b0, 8'b0000_0000, 8'b0001_0000, 4, 0, 3, 0, 1);
        // bit 6 has p and n set (p wins), n at bit 3
        run_one("t5_priority", 1'b0, 8'b0100_0000, 8'b0100_1000, 6, 1, 2, 0, 0);
        // leading digit at bit 1 with counter at bit 0: shift reaches W-1
        run_one("t6_maxshift", 1'b0, 8'b0000_0010, 8'b0000_0001, 1, 1, 7, 0, 0);
        // invalid with a counter-opposite digit below must not set corr
        run_one("t7_inv_nocorr", 1'b1, 8'b0010_0000, 8'b0000_0100, 5, 0, 2, 0, 1);

        // Backpressure: A..D with k = 7..4, shifts 0..3
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(1'b0, 8'b1000_0000, 8'b0);
        tick();
        chk("bp_ready_after_1", int'(in_ready), 1);
        drive(1'b0, 8'b0100_0000, 8'b0);
        tick();
        chk("bp_ready_after_2", int'(in_ready), 0);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_hold0_shift", int'(shift_amt), 0);
        drive(1'b0, 8'b0010_0000, 8'b0);
        tick();
        chk("bp_hold1_shift", int'(shift_amt), 0);
        chk("bp_hold1_lead", int'(lead_pos), 7);
        chk("bp_hold1_ready", int'(in_ready), 0);
        tick();
        chk("bp_hold2_shift", int'(shift_amt), 0);
        chk("bp_hold2_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", int'(in_ready), 1);
        tick();
        chk("bp_out_b", int'(shift_amt), 1);
        chk("bp_out_b_valid", int'(out_valid), 1);
        drive(1'b0, 8'b0001_0000, 8'b0);
        tick();
        chk("bp_out_c", int'(shift_amt), 2);
        in_valid = 1'b0;
        tick();
        chk("bp_out_d", int'(shift_amt), 3);
        chk("bp_out_d_valid", int'(out_valid), 1);
        tick();
        chk("bp_empty", int'(out_valid), 0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(1'b0, 8'b0010_0000, 8'b0000_0100);
        tick();
        drive(1'b1, 8'b0000_1000, 8'b1000_0000);
        tick();
        chk("mr_full_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_out_valid", int'(out_valid), 0);
        chk("mr_in_ready", int'(in_ready), 1);
        chk("mr_shift_amt", int'(shift_amt), 0);
        chk("mr_lead_pos", int'(lead_pos), 0);
        chk("mr_flags", int'({corr, zero, invalid}), 0);
        out_ready = 1'b1;
        tick();
        chk("mr_no_stale1", int'(out_valid), 0);
        tick();
        chk("mr_no_stale2", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
